cache_wb_drain: RTL

Write-buffer drain engine for the cache: the consumer end of the cache write-buffer FIFO. It pops {address, data} entries from a first-word-fall-through sync FIFO and issues them to memory as granted bursts of up to BURST_MAX beats. A final completion handshake closes each burst. It sits between the cache write buffer and the memory-side arbiter.

---
 rtl/cache_wb_drain_if.sv | 45 ++++
 rtl/cache_wb_drain.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cache_wb_drain_if.sv
// cache_wb_drain_if
//   Bundles the two buses of the write-buffer drain engine:
//   - FIFO side : fifo_read_data, fifo_empty, fifo_data_num (to drain), fifo_read (from drain)
//   - memory side: mem_req, mem_len, mem_wvalid, mem_waddr, mem_wdata, mem_wlast (from drain),
//                  mem_gnt, mem_wready, mem_done (to drain)
//   modport master : the drain engine
//   modport slave  : the environment (FIFO + memory arbiter)
interface cache_wb_drain_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int BURST_MAX  = 4
);
    localparam int NUM_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LEN_W = $clog2(BURST_MAX) + 1;

    logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_read_data;
    logic                             fifo_empty;
    logic [NUM_W-1:0]                 fifo_data_num;
    logic                             fifo_read;

    logic                             mem_req;
    logic [LEN_W-1:0]                 mem_len;
    logic                             mem_gnt;
    logic                             mem_wvalid;
    logic [ADDR_WIDTH-1:0]            mem_waddr;
    logic [DATA_WIDTH-1:0]            mem_wdata;
    logic                             mem_wlast;
    logic                             mem_wready;
    logic                             mem_done;

    modport master (
        input  fifo_read_data, fifo_empty, fifo_data_num,
        input  mem_gnt, mem_wready, mem_done,
        output fifo_read,
        output mem_req, mem_len, mem_wvalid, mem_waddr, mem_wdata, mem_wlast
    );

    modport slave (
        output fifo_read_data, fifo_empty, fifo_data_num,
        output mem_gnt, mem_wready, mem_done,
        input  fifo_read,
        input  mem_req, mem_len, mem_wvalid, mem_waddr, mem_wdata, mem_wlast
    );
endinterface

// File: rtl/cache_wb_drain.sv
// cache_wb_drain
//   Consumer end of the cache write-buffer FIFO. Pops {addr, data} entries from a
//   first-word-fall-through FIFO and issues them to memory as granted bursts of up to
//   BURST_MAX beats, each closed by a mem_done pulse.
//
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     soft_rst    synchronous clear (FSM to IDLE, counters cleared)
//     flush       level; allows partial bursts so everything drains
//     bus         cache_wb_drain_if.master (FIFO pop side + memory burst side)
//     busy        FSM not in IDLE
//     idle        FSM in IDLE and FIFO empty
//
//   Optional feature: define CACHE_WB_DRAIN_TIMEOUT_EN to force a partial burst after
//   TIMEOUT idle cycles with a non-empty FIFO and no other start condition.
module cache_wb_drain #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int BURST_MAX  = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             soft_rst,
    input  logic             flush,
    cache_wb_drain_if.master bus,
    output logic             busy,
    output logic             idle
);
    localparam int NUM_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LEN_W = $clog2(BURST_MAX) + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_WAIT_DONE} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [LEN_W-1:0] start_len;
    logic             full_start, flush_start, tmo_start, start, last_beat;

    // min(occupancy, BURST_MAX) compared at occupancy width; also covers the timeout
    // case, which only fires while occupancy is below BURST_MAX.
    assign start_len   = (bus.fifo_data_num >= NUM_W'(BURST_MAX)) ? LEN_W'(BURST_MAX)
                                                                   : LEN_W'(bus.fifo_data_num);
    assign full_start  = bus.fifo_data_num >= NUM_W'(BURST_MAX);
    assign flush_start = flush && !bus.fifo_empty;
    assign start       = full_start || flush_start || tmo_start;
    assign last_beat   = beat_q == (len_q - LEN_W'(1));

`ifdef CACHE_WB_DRAIN_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign tmo_start = (state_q == S_IDLE) && !bus.fifo_empty && (tmo_q == TMO_W'(TIMEOUT));
    // Counts only idle, non-empty cycles that are not already starting a burst;
    // anything else (start, empty, busy) holds it at zero.
    assign tmo_d = ((state_q == S_IDLE) && !bus.fifo_empty && !full_start && !flush_start && !tmo_start)
                   ? tmo_q + TMO_W'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        tmo_q <= '0;
        else if (soft_rst) tmo_q <= '0;
        else               tmo_q <= tmo_d;
    end
`else
    // Without the timeout feature a partial burst never starts on its own.
    assign tmo_start = (TIMEOUT < 0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            beat_q  <= '0;
        end else if (soft_rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = start_len;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_gnt) begin
                    beat_d  = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.mem_wready) begin
                    beat_d = beat_q + LEN_W'(1);
                    if (last_beat) state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // mem_done is only honoured here; pulses in other states are ignored.
                if (bus.mem_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: all driven from state, so soft_rst takes effect the cycle after it is seen.
    always_comb begin
        bus.fifo_read  = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_len    = '0;
        bus.mem_wvalid = 1'b0;
        bus.mem_waddr  = '0;
        bus.mem_wdata  = '0;
        bus.mem_wlast  = 1'b0;
        case (state_q)
            S_REQ: begin
                bus.mem_req = 1'b1;
                bus.mem_len = len_q;
            end
            S_DATA: begin
                bus.mem_wvalid = 1'b1;
                bus.mem_waddr  = bus.fifo_read_data[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
                bus.mem_wdata  = bus.fifo_read_data[DATA_WIDTH-1:0];
                bus.mem_wlast  = last_beat;
                // Safe without checking fifo_empty: len never exceeds occupancy at latch.
                bus.fifo_read  = bus.mem_wready;
            end
            default: ;
        endcase
    end

    assign busy = state_q != S_IDLE;
    assign idle = (state_q == S_IDLE) && bus.fifo_empty;
endmodule
